// File: rtl/crc_16_rx_controller.sv
// Serial CRC-16 (poly 0x8005, init 0xFFFF) packet receiver: accumulates data plus CRC
// field between sop and eop, then reports pass/fail with an error code.
module crc_16_rx_controller #(
    parameter int MAX_BYTES = 64,
    parameter int CNT_W     = 10
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             sop,
    input  logic             data_valid,
    input  logic             data_in,
    input  logic             eop,
    output logic             busy,
    output logic             crc_ok,
    output logic             crc_err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] bit_count
);

    localparam logic [CNT_W-1:0] MAX_BITS    = CNT_W'(MAX_BYTES * 8 + 16);
    localparam logic [CNT_W-1:0] MIN_BITS    = CNT_W'(16);
    localparam logic [15:0]      CRC_INIT    = 16'hFFFF;
    localparam logic [15:0]      CRC_POLY    = 16'h8005;
    localparam logic [15:0]      CRC_RESIDUE = 16'h800D;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_CRC   = 2'b01;
    localparam logic [1:0] CODE_SHORT = 2'b10;
    localparam logic [1:0] CODE_ABORT = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, CHECK, REPORT} state_t;

    state_t           state_reg, state_next;
    logic [15:0]      crc_reg, crc_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [1:0]       code_reg, code_next;
    logic             ok_reg, ok_next;
    logic             err_reg, err_next;

    // One serial CRC step: shift left, fold the polynomial in when the outgoing bit differs.
    logic        fb;
    logic [15:0] crc_shift;

    assign fb           = crc_reg[15] ^ data_in;
    assign crc_shift[0] = fb & CRC_POLY[0];

    genvar gi;
    generate
        for (gi = 1; gi < 16; gi++) begin : g_crc
            assign crc_shift[gi] = crc_reg[gi-1] ^ (fb & CRC_POLY[gi]);
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        crc_next   = crc_reg;
        count_next = count_reg;
        code_next  = code_reg;
        ok_next    = 1'b0;
        err_next   = 1'b0;

        case (state_reg)
            IDLE, REPORT: begin
                if (state_reg == REPORT) begin
                    state_next = IDLE;
                end
                // A sop together with eop is a zero-bit packet and goes straight to CHECK.
                if (sop) begin
                    crc_next   = CRC_INIT;
                    count_next = '0;
                    code_next  = CODE_NONE;
                    state_next = eop ? CHECK : RUN;
                end
            end
            RUN: begin
                if (sop) begin
                    err_next   = 1'b1;
                    code_next  = CODE_ABORT;
                    crc_next   = CRC_INIT;
                    count_next = '0;
                    state_next = eop ? CHECK : RUN;
                end else if (data_valid && (count_reg >= MAX_BITS)) begin
                    err_next   = 1'b1;
                    code_next  = CODE_ABORT;
                    state_next = REPORT;
                end else begin
                    if (data_valid) begin
                        crc_next   = crc_shift;
                        count_next = count_reg + CNT_W'(1);
                    end
                    if (eop) begin
                        state_next = CHECK;
                    end
                end
            end
            CHECK: begin
                if (sop) begin
                    err_next   = 1'b1;
                    code_next  = CODE_ABORT;
                    crc_next   = CRC_INIT;
                    count_next = '0;
                    state_next = eop ? CHECK : RUN;
                end else begin
                    state_next = REPORT;
                    if (count_reg < MIN_BITS) begin
                        err_next  = 1'b1;
                        code_next = CODE_SHORT;
                    end else if (crc_reg != CRC_RESIDUE) begin
                        err_next  = 1'b1;
                        code_next = CODE_CRC;
                    end else begin
                        ok_next   = 1'b1;
                        code_next = CODE_NONE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= IDLE;
            crc_reg   <= CRC_INIT;
            count_reg <= '0;
            code_reg  <= CODE_NONE;
            ok_reg    <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            crc_reg   <= crc_next;
            count_reg <= count_next;
            code_reg  <= code_next;
            ok_reg    <= ok_next;
            err_reg   <= err_next;
        end
    end

    assign busy      = (state_reg == RUN) || (state_reg == CHECK);
    assign crc_ok    = ok_reg;
    assign crc_err   = err_reg;
    assign err_code  = code_reg;
    assign bit_count = count_reg;

endmodule

// File: tb/tb_crc_16_rx_controller.sv
// Randomised bench for crc_16_rx_controller: packet-level expectations from a long-division
// CRC model, compared against the DUT outputs on every clock cycle.
module tb_crc_16_rx_controller;

    localparam int MAX_BYTES = 64;
    localparam int CNT_W     = 10;
    localparam int MAXB      = MAX_BYTES * 8 + 16;

    logic             clk = 1'b0;
    logic             n_rst = 1'b1;
    logic             sop = 1'b0;
    logic             data_valid = 1'b0;
    logic             data_in = 1'b0;
    logic             eop = 1'b0;
    logic             busy;
    logic             crc_ok;
    logic             crc_err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] bit_count;

    int checks = 0;
    int errors = 0;

    bit exp_live = 1'b0;
    int exp_busy, exp_ok, exp_err, exp_code, exp_cnt;
    int cur_code = 0;
    int cur_cnt  = 0;
    int pkt_no   = 0;
    bit pkt_bits[$];

    always #5 clk = ~clk;

    crc_16_rx_controller #(
        .MAX_BYTES(MAX_BYTES),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .sop       (sop),
        .data_valid(data_valid),
        .data_in   (data_in),
        .eop       (eop),
        .busy      (busy),
        .crc_ok    (crc_ok),
        .crc_err   (crc_err),
        .err_code  (err_code),
        .bit_count (bit_count)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_live) begin
            chk("busy", int'(busy), exp_busy);
            chk("crc_ok", int'(crc_ok), exp_ok);
            chk("crc_err", int'(crc_err), exp_err);
            chk("err_code", int'(err_code), exp_code);
            chk("bit_count", int'(bit_count), exp_cnt);
        end
    end

    // Textbook long division of the bit stream (first 16 bits inverted, 16 zeros appended)
    // by x^16+x^15+x^2+1; a good packet leaves the fixed residue 0x800D.
    function automatic logic [15:0] residue(input int n);
        logic [16:0] rem;
        logic        a;
        rem = '0;
        for (int i = 0; i < n + 16; i++) begin
            a = (i < n) ? logic'(pkt_bits[i]) : 1'b0;
            if (i < 16) a = ~a;
            rem = {rem[15:0], a};
            if (rem[16]) rem = rem ^ 17'h18005;
        end
        return rem[15:0];
    endfunction

    task automatic add_byte(input logic [7:0] v);
        for (int b = 0; b < 8; b++) pkt_bits.push_back(v[b]);
    endtask

    task automatic add_trailer();
        logic [15:0] c;
        c = residue(pkt_bits.size());
        for (int b = 15; b >= 0; b--) pkt_bits.push_back(~c[b]);
    endtask

    task automatic add_random_bits(input int n);
        for (int i = 0; i < n; i++) pkt_bits.push_back(1'($urandom_range(1)));
    endtask

    // Drive one cycle of inputs and record what the outputs must be in the following cycle.
    task automatic step(input int s, input int dv, input int d, input int e,
                        input int eb, input int eo, input int ee, input int ec, input int en);
        sop        = (s != 0);
        data_valid = (dv != 0);
        data_in    = (d != 0);
        eop        = (e != 0);
        @(posedge clk);
        #1;
        exp_busy = eb;
        exp_ok   = eo;
        exp_err  = ee;
        exp_code = ec;
        exp_cnt  = en;
        exp_live = 1'b1;
    endtask

    task automatic idle(input int k, input bit noise);
        for (int i = 0; i < k; i++) begin
            step(0, noise ? int'($urandom_range(1)) : 0, int'($urandom_range(1)),
                 noise ? int'($urandom_range(3) == 0) : 0, 0, 0, 0, cur_code, cur_cnt);
        end
    endtask

    // end_mode: 0 = leave packet running, 1 = eop then stop in the check cycle, 2 = complete.
    task automatic run_packet(input bit abort, input bit eop_last, input int gap_pct, input int end_mode);
        int n     = pkt_bits.size();
        int code  = abort ? 3 : 0;
        int cnt   = 0;
        bit ovf   = 1'b0;
        int r_ok, r_err, r_code, e;
        if (n == 0 && eop_last && end_mode == 2) begin
            step(1, 0, 0, 1, 1, 0, int'(abort), code, 0);
        end else begin
            step(1, 0, 0, 0, 1, 0, int'(abort), code, 0);
            for (int i = 0; i < n; i++) begin
                while ($urandom_range(99) < gap_pct) begin
                    if (ovf) step(0, 0, int'($urandom_range(1)), 0, 0, 0, 0, 3, MAXB);
                    else     step(0, 0, int'($urandom_range(1)), 0, 1, 0, 0, code, cnt);
                end
                e = (i == n - 1 && eop_last && end_mode != 0) ? 1 : 0;
                if (ovf) begin
                    step(0, 1, int'(pkt_bits[i]), e, 0, 0, 0, 3, MAXB);
                end else if (cnt == MAXB) begin
                    ovf = 1'b1;
                    step(0, 1, int'(pkt_bits[i]), e, 0, 0, 1, 3, MAXB);
                end else begin
                    cnt++;
                    step(0, 1, int'(pkt_bits[i]), e, 1, 0, 0, code, cnt);
                end
            end
            if (end_mode != 0 && (!eop_last || n == 0)) begin
                if (ovf) step(0, 0, 0, 1, 0, 0, 0, 3, MAXB);
                else     step(0, 0, 0, 1, 1, 0, 0, code, cnt);
            end
        end
        if (ovf) begin
            cur_code = 3;
            cur_cnt  = MAXB;
            $display("packet %0d: overflow after %0d bits, err_code=3", pkt_no, cnt);
        end else if (end_mode == 2) begin
            if (cnt < 16) begin
                r_ok = 0; r_err = 1; r_code = 2;
            end else if (residue(n) != 16'h800D) begin
                r_ok = 0; r_err = 1; r_code = 1;
            end else begin
                r_ok = 1; r_err = 0; r_code = 0;
            end
            step(0, int'($urandom_range(1)), int'($urandom_range(1)), 0, 0, r_ok, r_err, r_code, cnt);
            cur_code = r_code;
            cur_cnt  = cnt;
            $display("packet %0d: bits=%0d ok=%0d err_code=%0d", pkt_no, cnt, r_ok, r_code);
        end else begin
            $display("packet %0d: left open after %0d bits", pkt_no, cnt);
        end
        pkt_no++;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_crc_ok"}, int'(crc_ok), 0);
        chk({tag, "_crc_err"}, int'(crc_err), 0);
        chk({tag, "_err_code"}, int'(err_code), 0);
        chk({tag, "_bit_count"}, int'(bit_count), 0);
    endtask

    initial begin
        int kind, gap, nb, idx;
        bit el;

        #3 n_rst = 1'b0;
        #1 check_reset_outputs("reset");

        // Pin the model against hand-derived register values.
        pkt_bits.delete();
        chk("model_init", int'(residue(0)), 'hFFFF);
        pkt_bits.push_back(1'b1);
        chk("model_one_bit", int'(residue(1)), 'hFFFE);
        pkt_bits.delete();
        add_random_bits(0);
        for (int i = 0; i < 16; i++) pkt_bits.push_back(1'b0);
        chk("model_zero16", int'(residue(16)), 'h800D);

        repeat (2) @(posedge clk);
        #2 n_rst = 1'b1;
        @(posedge clk);
        #1;
        idle(3, 1'b1);

        // Zero-length data packet with CRC field 0x0000, then a back-to-back packet from REPORT.
        run_packet(1'b0, 1'b0, 0, 2);
        pkt_bits.delete();
        add_byte(8'h3A); add_byte(8'h01); add_byte(8'h02); add_byte(8'h03);
        add_trailer();
        chk("model_trailer48", int'(residue(48)), 'h800D);
        run_packet(1'b0, 1'b1, 20, 2);
        idle(2, 1'b0);
        pkt_bits[5] = ~pkt_bits[5];
        run_packet(1'b0, 1'b0, 0, 2);
        idle(2, 1'b1);

        // Short packet, zero-bit packet and overflow.
        pkt_bits.delete();
        add_random_bits(8);
        run_packet(1'b0, 1'b0, 0, 2);
        idle(1, 1'b0);
        pkt_bits.delete();
        run_packet(1'b0, 1'b1, 0, 2);
        idle(2, 1'b0);
        pkt_bits.delete();
        add_random_bits(MAXB + 1);
        run_packet(1'b0, 1'b0, 0, 2);
        idle(3, 1'b1);

        // Aborts from RUN and from CHECK, each followed by a good zero packet.
        pkt_bits.delete();
        add_random_bits(20);
        run_packet(1'b0, 1'b0, 0, 0);
        pkt_bits.delete();
        for (int i = 0; i < 16; i++) pkt_bits.push_back(1'b0);
        run_packet(1'b1, 1'b0, 0, 2);
        idle(1, 1'b0);
        pkt_bits.delete();
        add_random_bits(10);
        run_packet(1'b0, 1'b1, 0, 1);
        pkt_bits.delete();
        for (int i = 0; i < 16; i++) pkt_bits.push_back(1'b0);
        run_packet(1'b1, 1'b1, 0, 2);
        idle(2, 1'b0);

        // Reset mid-packet: outputs drop at once, no pulse, stray eop/data ignored afterwards.
        pkt_bits.delete();
        add_random_bits(20);
        run_packet(1'b0, 1'b0, 10, 0);
        #1;
        n_rst = 1'b0;
        sop = 1'b0; data_valid = 1'b0; eop = 1'b0;
        exp_busy = 0; exp_ok = 0; exp_err = 0; exp_code = 0; exp_cnt = 0;
        #1 check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        #1 n_rst = 1'b1;
        @(posedge clk);
        #1;
        cur_code = 0;
        cur_cnt  = 0;
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0, 0);
        idle(3, 1'b1);

        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(5));
            gap  = int'($urandom_range(3)) * 10;
            el   = 1'($urandom_range(1));
            pkt_bits.delete();
            case (kind)
                0, 1: begin
                    nb = int'($urandom_range(6));
                    for (int b = 0; b < nb; b++) add_byte(8'($urandom_range(255)));
                    add_trailer();
                    if (kind == 1) begin
                        idx = int'($urandom_range(pkt_bits.size() - 1));
                        pkt_bits[idx] = ~pkt_bits[idx];
                    end
                    run_packet(1'b0, el, gap, 2);
                end
                2: begin
                    add_random_bits(int'($urandom_range(15, 1)));
                    run_packet(1'b0, el, gap, 2);
                end
                3: begin
                    add_random_bits(int'($urandom_range(60, 16)));
                    run_packet(1'b0, el, gap, 2);
                end
                4: begin
                    add_random_bits(int'($urandom_range(30, 1)));
                    run_packet(1'b0, 1'b1, gap, int'($urandom_range(1)));
                    pkt_bits.delete();
                    nb = int'($urandom_range(4));
                    for (int b = 0; b < nb; b++) add_byte(8'($urandom_range(255)));
                    add_trailer();
                    run_packet(1'b1, el, gap, 2);
                end
                default: begin
                    run_packet(1'b0, 1'b1, 0, 2);
                end
            endcase
            idle(int'($urandom_range(3)), 1'b1);
        end

        idle(2, 1'b0);
        exp_live = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc_16_rx_controller.md
CRC_16_RX_CONTROLLER -- requirements
Module: crc_16_rx_controller

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 64: maximum data payload bytes per packet, excluding the 16-bit CRC field.
REQ-002 SHALL have parameter CNT_W, default 10: width of bit_count; must hold MAX_BYTES*8+16.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port n_rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port sop  input  1  start-of-packet strobe, one cycle.
REQ-006 SHALL have port data_valid  input  1  data_in is a valid serial bit this cycle.
REQ-007 SHALL have port data_in  input  1  serial packet bit, LSB-first, data then CRC field.
REQ-008 SHALL have port eop  input  1  end-of-packet strobe, one cycle.
REQ-009 SHALL have port busy  output  1  high while a packet is being accumulated.
REQ-010 SHALL have port crc_ok  output  1  one-cycle pulse: packet passed the check.
REQ-011 SHALL have port crc_err  output  1  one-cycle pulse: packet failed or was aborted.
REQ-012 SHALL have port err_code  output  2  00 none, 01 CRC mismatch, 10 short packet, 11 overflow/abort; valid with crc_err, held until the next sop.
REQ-013 SHALL have port bit_count  output  CNT_W  bits accepted in the current or last packet.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, CHECK, REPORT.
REQ-015 IDLE: sop -> RUN; CRC register loaded to 16'hFFFF; bit_count cleared to 0; err_code cleared to 00.
REQ-016 RUN: each data_valid bit SHALL update fb = crc[15]^data_in, crc <= {crc[14:0],0} ^ (fb ? 16'h8005 : 0), and increment bit_count.
REQ-017 RUN: eop -> CHECK; a data_valid bit in the same cycle as eop SHALL be accepted before the transition.
REQ-018 CHECK, evaluated in one cycle, in priority order:
 - bit_count < 16 -> err_code 10.
 - crc != 16'h800D -> err_code 01.
 - otherwise pass.
 Then -> REPORT.
REQ-019 REPORT SHALL pulse exactly one of crc_ok or crc_err for one cycle, then -> IDLE.
REQ-020 Latency SHALL be 2 cycles from the eop edge to the crc_ok/crc_err pulse.
REQ-021 busy SHALL be high in RUN and CHECK, low in IDLE and REPORT.
REQ-022 In RUN, a data_valid bit arriving when bit_count = MAX_BYTES*8+16 SHALL not be shifted; err_code SHALL be set to 11 and the FSM SHALL go -> REPORT with crc_err; the remaining bits are ignored until eop.
REQ-023 sop in RUN or CHECK SHALL abort the current packet:
 - crc_err pulses next cycle with err_code 11.
 - The new packet starts: CRC reset to FFFF, bit_count reset to 0, FSM to RUN. The pulse and the restart occur together.
REQ-024 sop in REPORT SHALL be honoured: the report pulse completes, and the FSM enters RUN instead of IDLE.
REQ-025 eop or data_valid in IDLE without a preceding sop SHALL be ignored; no pulse.
REQ-026 sop and eop asserted together in IDLE SHALL be treated as a zero-bit packet: crc_err pulses with err_code 10.
REQ-027 bit_count SHALL saturate and never wrap.

Reset
REQ-028 While n_rst=0, the block SHALL asynchronously force:
 - FSM to IDLE.
 - crc to 16'hFFFF.
 - bit_count to 0.
 - busy, crc_ok and crc_err to 0.
 - err_code to 00.
REQ-029 Reset asserted mid-packet SHALL discard the packet with no pulse; after release, no activity occurs until the next sop.

Verification
REQ-030 sop, then 16 bits of 0 (zero-length DATA packet, CRC field 0x0000), then eop -> crc_ok pulse 2 cycles after eop, bit_count=16, err_code=00.
REQ-031 sop, then bytes 3A,01,02,03 LSB-first followed by their model-computed complemented CRC16, then eop -> crc_ok, bit_count=48; the same packet with one data bit flipped -> crc_err, err_code=01.
REQ-032 sop, then 8 bits, then eop -> crc_err, err_code=10, bit_count=8.
REQ-033 sop, then 64*8+17 valid bits -> crc_err, err_code=11, bit_count=528, busy low after the pulse.
REQ-034 sop, 20 bits, then a second sop -> crc_err with err_code=11; the second packet (16 zero bits plus eop) -> crc_ok.
REQ-035 n_rst pulsed low mid-packet -> all outputs at reset values immediately, no crc_ok/crc_err pulse, and a later eop alone is ignored.
